// File: rtl/fetch_sequencer.sv
// fetch_sequencer: dual-issue fetch PC owner, imem request issue and show-ahead bundle queue toward decode.
module fetch_sequencer #(
    parameter int FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] total_instructions,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata0,
    input  logic [31:0] imem_rdata1,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        bundle_valid,
    input  logic        bundle_ready,
    output logic [31:0] bundle_pc,
    output logic [31:0] bundle_inst0,
    output logic [31:0] bundle_inst1,
    output logic [1:0]  bundle_mask,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FQ_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d, ppc_q;
    logic [33:0]   lim_q, lim_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   q_pc [FQ_DEPTH];
    logic [31:0]   q_i0 [FQ_DEPTH];
    logic [31:0]   q_i1 [FQ_DEPTH];
    logic [1:0]    q_m  [FQ_DEPTH];
    logic [33:0]   pc_ext, rpc_ext;
    logic          active, redir, credit, issue, enq, deq, mask1;

    // The single in-flight response is simply not enqueued when a redirect lands on its return cycle.
    always_comb begin
        pc_ext  = {2'b00, pc_q};
        rpc_ext = {2'b00, redirect_pc[31:2], 2'b00};
        active  = state_q == S_FETCH || state_q == S_DRAIN;
        redir   = redirect_valid && active;
        credit  = count_q + (AW+1)'(pend_q) < DEPTH;
        issue   = state_q == S_FETCH && pc_ext < lim_q && credit && !redir;
        enq     = pend_q && !redir;
        deq     = bundle_valid && bundle_ready && !redir;
        mask1   = {2'b00, ppc_q} + 34'd4 < lim_q;
        count_d = redir ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
        wr_d    = redir ? '0 : wr_q + AW'(enq);
        rd_d    = redir ? '0 : rd_q + AW'(deq);
        pend_d  = issue;
        state_d = state_q;
        pc_d    = pc_q;
        lim_d   = lim_q;
        if (!active && start) begin
            lim_d   = {total_instructions, 2'b00};
            pc_d    = '0;
            state_d = total_instructions != 32'd0 ? S_FETCH : S_DONE;
        end else if (redir) begin
            pc_d    = rpc_ext[31:0];
            state_d = rpc_ext < lim_q ? S_FETCH : S_DRAIN;
        end else if (issue) begin
            pc_d    = pc_q + 32'd8;
            state_d = pc_ext + 34'd8 >= lim_q ? S_DRAIN : S_FETCH;
        end else if (state_q == S_DRAIN && count_d == '0 && !pend_q) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ppc_q   <= '0;
            lim_q   <= '0;
            pend_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ppc_q   <= pc_q;
            lim_q   <= lim_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_q] <= ppc_q;
            q_i0[wr_q] <= imem_rdata0;
            q_i1[wr_q] <= mask1 ? imem_rdata1 : 32'h0;
            q_m[wr_q]  <= {mask1, 1'b1};
        end
    end

    assign imem_req     = issue;
    assign imem_addr    = pc_q;
    assign bundle_valid = count_q != '0;
    assign bundle_pc    = bundle_valid ? q_pc[rd_q] : 32'h0;
    assign bundle_inst0 = bundle_valid ? q_i0[rd_q] : 32'h0;
    assign bundle_inst1 = bundle_valid ? q_i1[rd_q] : 32'h0;
    assign bundle_mask  = bundle_valid ? q_m[rd_q] : 2'b00;
    assign busy         = active;
    assign done         = state_q == S_DONE;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven and hand-sequenced checks of fetch_sequencer against a behavioural imem.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, bundle_ready;
    logic [31:0] total_instructions, redirect_pc;
    logic        imem_req, bundle_valid, busy, done;
    logic [31:0] imem_addr, imem_rdata0, imem_rdata1, bundle_pc, bundle_inst0, bundle_inst1;
    logic [1:0]  bundle_mask;
    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.FQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .total_instructions(total_instructions),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready), .bundle_pc(bundle_pc),
        .bundle_inst0(bundle_inst0), .bundle_inst1(bundle_inst1), .bundle_mask(bundle_mask),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return 32'hC0DE0000 ^ a;
    endfunction

    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata0 <= mw(imem_addr);
            imem_rdata1 <= mw(imem_addr + 32'd4);
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_bundle(input string n, input logic ev, input logic [31:0] epc, input logic [1:0] em);
        chk({n, "_valid"}, 32'(bundle_valid), 32'(ev));
        chk({n, "_pc"}, bundle_pc, ev ? epc : 32'h0);
        chk({n, "_mask"}, 32'(bundle_mask), ev ? 32'(em) : 32'h0);
        chk({n, "_inst0"}, bundle_inst0, ev ? mw(epc) : 32'h0);
        chk({n, "_inst1"}, bundle_inst1, (ev && em[1]) ? mw(epc + 32'd4) : 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bundle_ready = 1'b1;
        total_instructions = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        st;
        logic [31:0] tot;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  em;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t tv [19];
    int npulse, got, k;

    initial begin
        // total=5 run, then total=16 with a redirect to 0x24 (low bits forced) one cycle after the 0x10 request
        tv[0]  = '{1'b1, 'd5,  1'b1, 1'b0, 'h0,   1'b0, 'h0,  1'b0, 'h0,  2'b00, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 'd5,  1'b1, 1'b0, 'h0,   1'b1, 'h0,  1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 'd5,  1'b1, 1'b0, 'h0,   1'b1, 'h8,  1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 'd5,  1'b1, 1'b0, 'h0,   1'b1, 'h10, 1'b1, 'h0,  2'b11, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 'd5,  1'b1, 1'b0, 'h0,   1'b0, 'h18, 1'b1, 'h8,  2'b11, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 'd5,  1'b1, 1'b0, 'h0,   1'b0, 'h18, 1'b1, 'h10, 2'b01, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 'd16, 1'b1, 1'b0, 'h0,   1'b0, 'h18, 1'b0, 'h0,  2'b00, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h0,  1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h8,  1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h10, 1'b1, 'h0,  2'b11, 1'b1, 1'b0};
        tv[10] = '{1'b0, 'd16, 1'b1, 1'b1, 'h26,  1'b0, 'h18, 1'b1, 'h8,  2'b11, 1'b1, 1'b0};
        tv[11] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h24, 1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[12] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h2C, 1'b0, 'h0,  2'b00, 1'b1, 1'b0};
        tv[13] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h34, 1'b1, 'h24, 2'b11, 1'b1, 1'b0};
        tv[14] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b1, 'h3C, 1'b1, 'h2C, 2'b11, 1'b1, 1'b0};
        tv[15] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b0, 'h44, 1'b1, 'h34, 2'b11, 1'b1, 1'b0};
        tv[16] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b0, 'h44, 1'b1, 'h3C, 2'b01, 1'b1, 1'b0};
        tv[17] = '{1'b0, 'd16, 1'b1, 1'b1, 'h8,   1'b0, 'h44, 1'b0, 'h0,  2'b00, 1'b0, 1'b1};
        tv[18] = '{1'b0, 'd16, 1'b1, 1'b0, 'h0,   1'b0, 'h44, 1'b0, 'h0,  2'b00, 1'b0, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bundle_ready = 1'b1;
        total_instructions = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk_bundle("rst", 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            start = tv[i].st;
            total_instructions = tv[i].tot;
            bundle_ready = tv[i].rdy;
            redirect_valid = tv[i].rv;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tv[i].ereq));
            chk($sformatf("v%0d_addr", i), imem_addr, tv[i].eaddr);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].eb));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].ed));
            chk_bundle($sformatf("v%0d", i), tv[i].ev, tv[i].epc, tv[i].em);
            @(negedge clk);
        end
        start = 1'b0;
        redirect_valid = 1'b0;

        // backpressure: queue fills, requests stop, then 8 ordered bundles after release
        do_reset();
        start = 1'b1;
        total_instructions = 32'd16;
        bundle_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (imem_req) npulse++;
            @(negedge clk);
        end
        chk("bp_pulses_full", 32'(npulse), 32'd4);
        bundle_ready = 1'b1;
        #1;
        chk("bp_full_req", 32'(imem_req), 32'h0);
        chk_bundle("bp_full", 1'b1, 32'h0, 2'b11);
        got = 0;
        k = 0;
        while (!done && k < 100) begin
            if (k == 1) chk("bp_resume", 32'(imem_req), 32'h1);
            if (imem_req) npulse++;
            if (bundle_valid) begin
                chk_bundle($sformatf("bp_b%0d", got), 1'b1, 32'(got * 8), 2'b11);
                got++;
            end
            @(negedge clk);
            #1;
            k++;
        end
        chk("bp_timeout", 32'(k < 100), 32'h1);
        chk("bp_count", 32'(got), 32'd8);
        chk("bp_pulses", 32'(npulse), 32'd8);
        chk("bp_done", 32'(done), 32'h1);
        @(negedge clk);

        // empty program goes straight to DONE
        do_reset();
        start = 1'b1;
        total_instructions = 32'd0;
        #1;
        chk("z_done_pre", 32'(done), 32'h0);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("z%0d_done", c), 32'(done), 32'h1);
            chk($sformatf("z%0d_busy", c), 32'(busy), 32'h0);
            chk($sformatf("z%0d_req", c), 32'(imem_req), 32'h0);
            chk($sformatf("z%0d_valid", c), 32'(bundle_valid), 32'h0);
            @(negedge clk);
        end

        // redirect beyond the program end drains without fetching
        do_reset();
        start = 1'b1;
        total_instructions = 32'd16;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ro_req0", 32'(imem_req), 32'h1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("ro_req_redir", 32'(imem_req), 32'h0);
        chk("ro_valid_redir", 32'(bundle_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("ro_busy", 32'(busy), 32'h1);
        chk("ro_done_drain", 32'(done), 32'h0);
        chk("ro_req_drain", 32'(imem_req), 32'h0);
        chk("ro_valid_drain", 32'(bundle_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("ro_done", 32'(done), 32'h1);
        chk("ro_req_done", 32'(imem_req), 32'h0);
        chk("ro_valid_done", 32'(bundle_valid), 32'h0);
        chk("ro_addr", imem_addr, 32'h100);
        @(negedge clk);

        // async reset mid-burst with two bundles queued
        do_reset();
        start = 1'b1;
        total_instructions = 32'd16;
        bundle_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_bundle("mr_pre", 1'b1, 32'h0, 2'b11);
        chk("mr_pre_req", 32'(imem_req), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_req", 32'(imem_req), 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_done", 32'(done), 32'h0);
        chk_bundle("mr", 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        bundle_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("mr%0d_req", c), 32'(imem_req), 32'h0);
            chk($sformatf("mr%0d_valid", c), 32'(bundle_valid), 32'h0);
            chk($sformatf("mr%0d_busy", c), 32'(busy), 32'h0);
            chk($sformatf("mr%0d_done", c), 32'(done), 32'h0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
